// File: rtl/req_ack_pkg.sv
// Shared types and widths for the req/ack responder.
package req_ack_pkg;

  localparam int unsigned LAT_W = 4;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/req_ack_timer.sv
// Wait counter for a pending request; raises a sticky flag once the wait hits TIMEOUT.
module req_ack_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;

  // Counter clears whenever no request is waiting; saturates at TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
      expired  <= 1'b0;
    end else begin
      if (!run) begin
        wait_cnt <= '0;
      end else if (wait_cnt != TW'(TIMEOUT)) begin
        wait_cnt <= wait_cnt + TW'(1);
      end
      if (run && (wait_cnt == TW'(TIMEOUT - 1))) begin
        expired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_ack_responder.sv
// Acknowledging side of a req/ack level handshake with programmable latency,
// stall support, and sticky timeout / protocol-violation flags.
module req_ack_responder
  import req_ack_pkg::*;
#(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DW      = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [DW-1:0]    req_data,
  input  logic             stall,
  output logic             ack,
  output logic [DW-1:0]    ack_data,
  output logic [CNT_W-1:0] resp_cnt,
  output logic             err_timeout,
  output logic             err_proto
);

  localparam bit ZERO_LAT = (LATENCY == 0);
  localparam logic [LAT_W-1:0] LOAD = ZERO_LAT ? '0 : LAT_W'(LATENCY - 1);

  state_t           state;
  state_t           state_next;
  logic [LAT_W-1:0] cnt;
  logic [LAT_W-1:0] cnt_next;
  logic [DW-1:0]    data_q;
  logic             capture;
  logic             proto_set;
  logic             ack_fsm;
  logic             timer_run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= '0;
      resp_cnt  <= '0;
      err_proto <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) data_q <= req_data;
      if (ack) resp_cnt <= resp_cnt + CNT_W'(1);
      if (proto_set) err_proto <= 1'b1;
    end
  end

  // Zero latency never leaves IDLE; the ack path is then purely combinational.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    proto_set  = 1'b0;
    ack_fsm    = 1'b0;
    case (state)
      IDLE: begin
        if (req && !ZERO_LAT) begin
          capture    = 1'b1;
          cnt_next   = LOAD;
          state_next = (LATENCY == 1) ? ACK : COUNT;
        end
      end
      COUNT: begin
        if (!req) begin
          state_next = IDLE;
          proto_set  = 1'b1;
        end else if (!stall) begin
          cnt_next = cnt - LAT_W'(1);
          if (cnt <= LAT_W'(1)) state_next = ACK;
        end
      end
      ACK: begin
        if (stall) begin
          if (!req) begin
            state_next = IDLE;
            proto_set  = 1'b1;
          end
        end else begin
          ack_fsm    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ack      = (ZERO_LAT ? (req & ~stall) : ack_fsm) & ~rst;
  assign ack_data = ack ? (ZERO_LAT ? req_data : data_q) : '0;

  // The wait clock runs only while a request stays pending across an edge.
  assign timer_run = (state != IDLE) && (state_next != IDLE);

  req_ack_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (timer_run),
    .expired(err_timeout)
  );

endmodule

// File: tb/tb_req_ack_responder.sv
// Randomized scoreboard bench for req_ack_responder at latencies 1, 0 and 3.
module tb_req_ack_responder;

  localparam int LAT [3] = '{1, 0, 3};
  localparam int TMO [3] = '{64, 64, 8};

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rq  [3];
  logic [7:0]  rd  [3];
  logic        st  [3];
  logic        ak  [3];
  logic [7:0]  ad  [3];
  logic [15:0] rc  [3];
  logic        et  [3];
  logic        ep  [3];

  int          cyc   = 0;
  int          total = 0;
  int          bad   = 0;
  exp_t        expq [$];
  logic [15:0] exp_cnt [3];
  bit          exp_to  [3];
  bit          exp_pe  [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  req_ack_responder #(.LATENCY(1), .DW(8), .TIMEOUT(64)) u_lat1 (
    .clk(clk), .rst(rst), .req(rq[0]), .req_data(rd[0]), .stall(st[0]),
    .ack(ak[0]), .ack_data(ad[0]), .resp_cnt(rc[0]),
    .err_timeout(et[0]), .err_proto(ep[0]));

  req_ack_responder #(.LATENCY(0), .DW(8), .TIMEOUT(64)) u_lat0 (
    .clk(clk), .rst(rst), .req(rq[1]), .req_data(rd[1]), .stall(st[1]),
    .ack(ak[1]), .ack_data(ad[1]), .resp_cnt(rc[1]),
    .err_timeout(et[1]), .err_proto(ep[1]));

  req_ack_responder #(.LATENCY(3), .DW(8), .TIMEOUT(8)) u_lat3 (
    .clk(clk), .rst(rst), .req(rq[2]), .req_data(rd[2]), .stall(st[2]),
    .ack(ak[2]), .ack_data(ad[2]), .resp_cnt(rc[2]),
    .err_timeout(et[2]), .err_proto(ep[2]));

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s inst%0d: got 0x%0h want 0x%0h (cycle %0d)", name, k, act, want, cyc);
    end
  endtask

  // Monitor: runs mid-cycle, pops the scoreboard on every ack and tracks counters/flags.
  task automatic mon();
    exp_t e;
    while (expq.size() > 0 && expq[0].at < cyc + 1) begin
      e = expq.pop_front();
      total++;
      bad++;
      $display("FAIL ack_missing inst%0d: got no ack want ack at edge %0d", e.inst, e.at);
    end
    for (int k = 0; k < 3; k++) begin
      if (ak[k] === 1'b1) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack inst%0d: got ack=1 want ack=0 at edge %0d", k, cyc + 1);
        end else begin
          e = expq.pop_front();
          chk("ack_inst", k, 32'(k), 32'(e.inst));
          chk("ack_edge", k, 32'(cyc + 1), 32'(e.at));
          chk("ack_data", k, 32'(ad[k]), 32'(e.data));
        end
      end
      chk("resp_cnt", k, 32'(rc[k]), 32'(exp_cnt[k]));
      chk("err_timeout", k, 32'(et[k]), 32'(exp_to[k]));
      chk("err_proto", k, 32'(ep[k]), 32'(exp_pe[k]));
    end
  endtask

  task automatic idle(input int k, input int n);
    rq[k] = 1'b0;
    for (int i = 0; i < n; i++) begin
      st[k] = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    st[k] = 1'b0;
  endtask

  // One request on a latency>=1 instance. The ack lands on the edge closing the
  // LAT-th unstalled cycle after acceptance; abort_j>0 drops req in that cycle.
  task automatic txn(input int k, input logic [7:0] d, input int lead, input int pct,
                     input int abort_j, input bit early);
    bit   s [$];
    int   n;
    int   i;
    int   t;
    exp_t e;
    n = 0;
    while (n < LAT[k]) begin
      bit b;
      b = (s.size() < lead) ? 1'b1 : ($urandom_range(99) < pct);
      s.push_back(b);
      if (!b) n++;
    end
    i = s.size();
    rq[k] = 1'b1;
    rd[k] = d;
    st[k] = 1'($urandom_range(1));
    t = cyc + 1;
    if (abort_j == 0) begin
      e.inst = k;
      e.data = d;
      e.at   = t + i;
      expq.push_back(e);
    end
    @(posedge clk); #1;
    for (int j = 1; j <= i; j++) begin
      st[k] = s[j-1];
      rd[k] = d + 8'h11;
      if (j == abort_j) rq[k] = 1'b0;
      if (j == i && early) rq[k] = 1'b0;
      @(posedge clk); #1;
      if (j == TMO[k] && i > TMO[k] && (abort_j == 0 || abort_j > j)) exp_to[k] = 1'b1;
      if (j == abort_j) begin
        exp_pe[k] = 1'b1;
        break;
      end
    end
    if (abort_j == 0) exp_cnt[k] = exp_cnt[k] + 16'd1;
    rq[k] = 1'b0;
    st[k] = 1'b0;
  endtask

  // One cycle on the zero-latency instance: every unstalled request cycle is a handshake.
  task automatic zero_cycle(input bit r, input bit s_, input logic [7:0] d);
    exp_t e;
    rq[1] = r;
    st[1] = s_;
    rd[1] = d;
    if (r && !s_) begin
      e.inst = 1;
      e.data = d;
      e.at   = cyc + 1;
      expq.push_back(e);
    end
    @(posedge clk); #1;
    if (r && !s_) exp_cnt[1] = exp_cnt[1] + 16'd1;
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rq[k] = 1'b0; rd[k] = 8'h00; st[k] = 1'b0;
      exp_cnt[k] = 16'd0; exp_to[k] = 1'b0; exp_pe[k] = 1'b0;
    end
    fork
      forever begin
        @(negedge clk);
        mon();
      end
    join_none
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ack", k, 32'(ak[k]), 32'd0);
      chk("rst_ack_data", k, 32'(ad[k]), 32'd0);
      chk("rst_resp_cnt", k, 32'(rc[k]), 32'd0);
      chk("rst_err_timeout", k, 32'(et[k]), 32'd0);
      chk("rst_err_proto", k, 32'(ep[k]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Latency 1: directed single request, random traffic, then a stalled-ACK abandon.
    txn(0, 8'hA5, 0, 0, 0, 1'b0);
    idle(0, 2);
    repeat (20) begin
      txn(0, 8'($urandom), 0, 30, 0, 1'($urandom_range(1)));
      idle(0, $urandom_range(2));
    end
    txn(0, 8'h3C, 1, 0, 1, 1'b0);
    idle(0, 1);

    // Latency 0: held request, then random req/stall mix.
    repeat (4) zero_cycle(1'b1, 1'b0, 8'($urandom));
    repeat (40) zero_cycle(1'($urandom_range(1)), ($urandom_range(3) == 0), 8'($urandom));
    zero_cycle(1'b0, 1'b0, 8'h00);

    // Latency 3 / timeout 8: stall in COUNT with payload change, timeout, random, abort.
    txn(2, 8'h11, 2, 0, 0, 1'b0);
    idle(2, 1);
    txn(2, 8'($urandom), 10, 0, 0, 1'b0);
    idle(2, 1);
    repeat (15) begin
      txn(2, 8'($urandom), 0, 30, 0, 1'($urandom_range(1)));
      idle(2, $urandom_range(2));
    end
    txn(2, 8'h77, 0, 0, 2, 1'b0);
    idle(2, 2);

    // Reset while ack is high: outputs clear at once, request is discarded.
    rq[2] = 1'b1; rd[2] = 8'h5A; st[2] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    rq[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_cnt[k] = 16'd0; exp_to[k] = 1'b0; exp_pe[k] = 1'b0;
    end
    #1;
    chk("mid_rst_ack", 2, 32'(ak[2]), 32'd0);
    chk("mid_rst_ack_data", 2, 32'(ad[2]), 32'd0);
    chk("mid_rst_resp_cnt", 2, 32'(rc[2]), 32'd0);
    chk("mid_rst_err_timeout", 2, 32'(et[2]), 32'd0);
    chk("mid_rst_err_proto", 2, 32'(ep[2]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2, 3);
    txn(2, 8'hC3, 0, 0, 0, 1'b0);
    idle(2, 3);

    chk("queue_drained", 0, 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
